dm_multicycle: RTL and testbench
================================

// Module: dm_multicycle
// PURPOSE
//  Data-memory stage for the MIPS core. Generalises the single-cycle word DM to a
//  parametrised depth and read latency, with byte, halfword and word loads/stores.
//  Sits between ALU result (Adr) and register write-back; returns load data, nextPC
//  (JAL) or passes Adr through. Asserts Stall toward the pipeline while a load is in flight.
// PARAMETERS
//  DEPTH       1024  words of storage; index = Adr[AW+1:2], AW=$clog2(DEPTH), wraps modulo DEPTH
//  LAT         2     read latency in cycles, legal range 1..15
//  BIG_ENDIAN  1     1: byte at Adr[1:0]=0 is bits 31:24; 0: bits 7:0
// PORTS
//  CLK     in   1   clock, rising edge
//  RST     in   1   asynchronous reset, active-low
//  Adr     in   32  ALU result / effective address
//  Wdata   in   32  store data; low byte/halfword used for SB/SH
//  nextPC  in   32  PC+4, returned for JAL
//  Ins     in   32  instruction; opcode Ins[31:26]; held stable by the pipeline while Stall=1
//  Rdata   out  32  write-back value
//  Stall   out  1   1 = hold the pipeline, load not yet complete
//  Exc     out  1   misaligned-access flag (see CONFIGURATION)
// BEHAVIOUR
//  Reset (RST=0, any time): state IDLE, cnt=0, rdata_q=0, Stall=0, Exc=0, Rdata follows IDLE decode.
//   In-flight load is abandoned, no write occurs. Memory contents are not cleared.
//  Decode: LB 20 LH 21 LW 23 LBU 24 LHU 25 SB 28 SH 29 SW 2B JAL 03 (hex opcodes).
//  Non-memory op: Rdata = Adr (JAL: nextPC), combinational, Stall=0.
//  Store: single cycle, no stall. Write at the posedge with byte enables from Adr[1:0]:
//   SB 1 lane, SH 2 lanes (Adr[1] picks the half), SW all 4. Rdata = 0.
//  Load FSM: IDLE -> WAIT -> DONE -> IDLE.
//   IDLE: load decoded -> Stall=1 (combinational), cnt<=LAT-1, go WAIT.
//   WAIT: Stall=1. cnt!=0: cnt--. cnt==0: read the word, extract/extend the lane into rdata_q, go DONE.
//   DONE: Stall=0, Rdata=rdata_q. Pipeline advances on this edge, then unconditional IDLE.
//   Stall is high for LAT+1 cycles; result is valid in cycle LAT+2 after the load is presented.
//  Extension: LB/LH sign-extend; LBU/LHU zero-extend; LW returns the whole word.
//  Back-to-back loads: the second load is seen in IDLE after DONE and stalls normally.
//   A load immediately after a store to the same word returns the stored data
//   (the write completed before the read).
//  Ins changing while Stall=1 is a protocol violation. Behaviour is undefined; assertion in bench.
// CONFIGURATION
//  DM_MISALIGN_TRAP_EN defined: misaligned = (LH/LHU/SH & Adr[0]) | (LW/SW & Adr[1:0]!=0).
//   On misalignment: Exc=1 combinational, store suppressed, load returns 0 with no stall (FSM stays IDLE).
//  Undefined: Exc tied 0; low address bits below access size are ignored (forced aligned).
// STRUCTURE
//  common_param.vh: opcode constants above, DMEM_SIZE (default for DEPTH), FSM state encodings.
//  Sub-module dm_bank: DEPTH x 32 RAM, 4 byte-write enables, synchronous read port.
//  Top holds decode, lane extraction/extension, FSM, counter and output mux.
// TESTING
//  LAT=2: SW 0x11223344 @0x10, then LW @0x10 -> Stall=1 for 3 cycles, Rdata=0x11223344 in cycle 4.
//  SB 0xA5 @0x21, then LB @0x21 -> 0xFFFFFFA5; LBU -> 0x000000A5; other lanes of word 8 unchanged.
//  SH 0x8001 @0x32, then LH @0x32 -> 0xFFFF8001; LHU @0x30 returns the untouched half.
//  Back-to-back LW @0x0, LW @0x4 -> two separate stall windows of LAT+1, correct data each.
//  RST low in WAIT -> Stall=0 next sample, state IDLE; a following ADD passes Adr to Rdata.
//  With DM_MISALIGN_TRAP_EN: SW @0x2 -> Exc=1, word 0 unchanged; LW @0x6 -> Rdata=0, no stall.

Source files
------------

// File: rtl/dm_multicycle_pkg.sv
// Shared opcodes, FSM encodings and lane helpers for the multi-cycle data-memory stage.
package dm_multicycle_pkg;

    localparam int unsigned DMEM_SIZE = 1024;

    localparam logic [5:0] OP_LB  = 6'h20;
    localparam logic [5:0] OP_LH  = 6'h21;
    localparam logic [5:0] OP_LW  = 6'h23;
    localparam logic [5:0] OP_LBU = 6'h24;
    localparam logic [5:0] OP_LHU = 6'h25;
    localparam logic [5:0] OP_SB  = 6'h28;
    localparam logic [5:0] OP_SH  = 6'h29;
    localparam logic [5:0] OP_SW  = 6'h2B;
    localparam logic [5:0] OP_JAL = 6'h03;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2
    } size_e;

    typedef struct packed {
        logic  is_load;
        logic  is_store;
        logic  is_jal;
        logic  sign;
        size_e size;
    } dec_t;

    function automatic dec_t decode(input logic [5:0] op);
        dec_t d;
        d = '0;
        d.size = SZ_WORD;
        case (op)
            OP_LB:   begin d.is_load  = 1'b1; d.sign = 1'b1; d.size = SZ_BYTE; end
            OP_LH:   begin d.is_load  = 1'b1; d.sign = 1'b1; d.size = SZ_HALF; end
            OP_LW:   begin d.is_load  = 1'b1; d.size = SZ_WORD; end
            OP_LBU:  begin d.is_load  = 1'b1; d.size = SZ_BYTE; end
            OP_LHU:  begin d.is_load  = 1'b1; d.size = SZ_HALF; end
            OP_SB:   begin d.is_store = 1'b1; d.size = SZ_BYTE; end
            OP_SH:   begin d.is_store = 1'b1; d.size = SZ_HALF; end
            OP_SW:   begin d.is_store = 1'b1; d.size = SZ_WORD; end
            OP_JAL:  d.is_jal = 1'b1;
            default: ;
        endcase
        return d;
    endfunction

    // Byte-lane bit k covers word bits 8k+7:8k; big-endian puts address byte 0 in lane 3.
    function automatic logic [3:0] lane_mask(input size_e sz, input logic [1:0] a, input logic be);
        logic [1:0] k;
        logic [3:0] m;
        k = be ? (2'd3 - a) : a;
        case (sz)
            SZ_BYTE: m = 4'b0001 << k;
            SZ_HALF: m = (be ^ a[1]) ? 4'b1100 : 4'b0011;
            default: m = 4'b1111;
        endcase
        return m;
    endfunction

    function automatic logic [31:0] store_data(input size_e sz, input logic [31:0] d);
        logic [31:0] r;
        case (sz)
            SZ_BYTE: r = {4{d[7:0]}};
            SZ_HALF: r = {2{d[15:0]}};
            default: r = d;
        endcase
        return r;
    endfunction

    function automatic logic [31:0] load_extend(input size_e sz, input logic sgn,
                                                input logic [1:0] a, input logic be,
                                                input logic [31:0] w);
        logic [1:0]  k;
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        k = be ? (2'd3 - a) : a;
        b = w[{k, 3'b000} +: 8];
        h = (be ^ a[1]) ? w[31:16] : w[15:0];
        case (sz)
            SZ_BYTE: r = {{24{sgn & b[7]}}, b};
            SZ_HALF: r = {{16{sgn & h[15]}}, h};
            default: r = w;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/dm_multicycle_bank.sv
// dm_bank: DEPTH x 32 storage with per-byte write enables and a registered read port.
module dm_bank #(
    parameter int unsigned DEPTH = 1024,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic          i_clk,
    input  logic [3:0]    i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic [31:0]   i_wdata,
    input  logic [AW-1:0] i_raddr,
    output logic [31:0]   o_rdata
);

    logic [31:0] r_mem [DEPTH];
    logic [31:0] r_rdata;

    // Read-before-write on a same-edge collision; the FSM never reads a word in the cycle it is written.
    always_ff @(posedge i_clk) begin
        for (int unsigned i = 0; i < 4; i++) begin
            if (i_we[i]) begin
                r_mem[i_waddr][8*i +: 8] <= i_wdata[8*i +: 8];
            end
        end
        r_rdata <= r_mem[i_raddr];
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/dm_multicycle.sv
// Multi-cycle data-memory stage: decode, byte/half/word access, load-latency FSM, write-back mux.
// Optional misaligned-access trap enabled by defining DM_MISALIGN_TRAP_EN.
module dm_multicycle
    import dm_multicycle_pkg::*;
#(
    parameter int unsigned DEPTH      = DMEM_SIZE,
    parameter int unsigned LAT        = 2,
    parameter logic        BIG_ENDIAN = 1'b1
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [31:0] Adr,
    input  logic [31:0] Wdata,
    input  logic [31:0] nextPC,
    input  logic [31:0] Ins,
    output logic [31:0] Rdata,
    output logic        Stall,
    output logic        Exc
);

    localparam int unsigned AW       = $clog2(DEPTH);
    localparam logic [3:0]  CNT_INIT = 4'(LAT - 1);

    logic [1:0]    r_state;
    logic [3:0]    r_cnt;
    logic [31:0]   r_rdata_q;

    dec_t          w_dec;
    logic          w_mis;
    logic          w_mem_op;
    logic          w_load_go;
    logic [3:0]    w_be;
    logic [3:0]    w_we;
    logic [31:0]   w_wdata;
    logic [AW-1:0] w_idx;
    logic [31:0]   w_bank_rdata;
    logic          w_unused;

    assign w_dec    = decode(Ins[31:26]);
    assign w_mem_op = w_dec.is_load | w_dec.is_store;
    assign w_idx    = Adr[AW+1:2];

`ifdef DM_MISALIGN_TRAP_EN
    assign w_mis = w_mem_op &
                   (((w_dec.size == SZ_HALF) & Adr[0]) |
                    ((w_dec.size == SZ_WORD) & (Adr[1:0] != 2'b00)));
`else
    assign w_mis = 1'b0;
`endif

    assign w_load_go = w_dec.is_load & ~w_mis & (r_state == ST_IDLE);
    assign w_be      = lane_mask(w_dec.size, Adr[1:0], BIG_ENDIAN);
    assign w_we      = (RST & w_dec.is_store & ~w_mis & (r_state == ST_IDLE)) ? w_be : 4'b0000;
    assign w_wdata   = store_data(w_dec.size, Wdata);

    dm_bank #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_bank (
        .i_clk   (CLK),
        .i_we    (w_we),
        .i_waddr (w_idx),
        .i_wdata (w_wdata),
        .i_raddr (w_idx),
        .o_rdata (w_bank_rdata)
    );

    // The bank registers the held load address every edge, so the word is ready when cnt reaches 0.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_state   <= ST_IDLE;
            r_cnt     <= '0;
            r_rdata_q <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_load_go) begin
                        r_cnt   <= CNT_INIT;
                        r_state <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (r_cnt != '0) begin
                        r_cnt <= r_cnt - 4'd1;
                    end else begin
                        r_rdata_q <= load_extend(w_dec.size, w_dec.sign, Adr[1:0],
                                                 BIG_ENDIAN, w_bank_rdata);
                        r_state   <= ST_DONE;
                    end
                end
                ST_DONE: r_state <= ST_IDLE;
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign Stall = RST & (w_load_go | (r_state == ST_WAIT));
    assign Exc   = RST & w_mis;

    always_comb begin
        Rdata = '0;
        case (r_state)
            ST_DONE: Rdata = r_rdata_q;
            ST_WAIT: Rdata = '0;
            default: begin
                if (w_dec.is_jal) begin
                    Rdata = nextPC;
                end else if (!w_mem_op) begin
                    Rdata = Adr;
                end
            end
        endcase
    end

    assign w_unused = ^{Ins[25:0], Adr[31:AW+2]};

endmodule

// File: tb/tb_dm_multicycle.sv
// Self-checking bench for dm_multicycle: table of accesses through a result scoreboard, plus reset-in-flight sequence.
module tb_dm_multicycle;

    localparam int unsigned LAT = 2;

    localparam logic [5:0] LB  = 6'h20, LH  = 6'h21, LW = 6'h23, LBU = 6'h24, LHU = 6'h25;
    localparam logic [5:0] SB  = 6'h28, SH  = 6'h29, SW = 6'h2B, JAL = 6'h03, ADD = 6'h00;

    logic        CLK = 1'b0;
    logic        RST;
    logic [31:0] Adr, Wdata, nextPC, Ins;
    logic [31:0] Rdata;
    logic        Stall, Exc;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [5:0]  op;
        logic [31:0] adr;
        logic [31:0] wd;
        logic [31:0] npc;
        logic [31:0] exp;
        logic        exc;
        int          stall;
    } vec_t;

    vec_t        tbl[$];
    logic [31:0] q_exp[$];

    dm_multicycle #(
        .DEPTH      (1024),
        .LAT        (LAT),
        .BIG_ENDIAN (1'b1)
    ) dut (
        .CLK    (CLK),
        .RST    (RST),
        .Adr    (Adr),
        .Wdata  (Wdata),
        .nextPC (nextPC),
        .Ins    (Ins),
        .Rdata  (Rdata),
        .Stall  (Stall),
        .Exc    (Exc)
    );

    always #5 CLK = ~CLK;

    // Protocol: the instruction must not change while the previous cycle was stalled.
    logic [31:0] prev_ins = '0;
    logic        prev_stall = 1'b0;
    always @(posedge CLK) begin
        if (RST && prev_stall) begin
            assert (Ins == prev_ins) else $error("Ins changed during Stall");
        end
        prev_ins   <= Ins;
        prev_stall <= Stall & RST;
    end

    function automatic bit is_load_op(input logic [5:0] op);
        return (op == LB) || (op == LH) || (op == LW) || (op == LBU) || (op == LHU);
    endfunction

    function automatic void add(input logic [5:0] op, input logic [31:0] adr, input logic [31:0] wd,
                                input logic [31:0] npc, input logic [31:0] exp, input logic exc);
        vec_t v;
        v.op    = op;
        v.adr   = adr;
        v.wd    = wd;
        v.npc   = npc;
        v.exp   = exp;
        v.exc   = exc;
        v.stall = (is_load_op(op) && !exc) ? int'(LAT) + 1 : 0;
        tbl.push_back(v);
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Drive one instruction, then wait (bounded) for Stall to drop and compare the scoreboard head.
    task automatic issue(input vec_t v, input int idx);
        int          stalls;
        bit          done;
        logic [31:0] e;
        Ins    = {v.op, 26'h0};
        Adr    = v.adr;
        Wdata  = v.wd;
        nextPC = v.npc;
        q_exp.push_back(v.exp);
        stalls = 0;
        done   = 1'b0;
        for (int c = 0; c < 40 && !done; c++) begin
            @(negedge CLK);
            if (Stall) begin
                stalls++;
            end else begin
                e = q_exp.pop_front();
                check($sformatf("vec%0d_rdata", idx), Rdata, e);
                check($sformatf("vec%0d_stall", idx), 32'(stalls), 32'(v.stall));
                check($sformatf("vec%0d_exc", idx), {31'b0, Exc}, {31'b0, v.exc});
                done = 1'b1;
            end
            @(posedge CLK);
            #1;
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL vec%0d_timeout: got stall=%0d expected release", idx, stalls);
            void'(q_exp.pop_front());
        end
    endtask

    task automatic run_table(input int base);
        for (int i = 0; i < tbl.size(); i++) begin
            issue(tbl[i], base + i);
        end
        tbl.delete();
    endtask

    initial begin
        RST    = 1'b0;
        Ins    = {ADD, 26'h0};
        Adr    = 32'h5A5A5A5A;
        Wdata  = '0;
        nextPC = 32'h0000_0100;

        add(SW,  32'h10, 32'h11223344, 0, 32'h00000000, 1'b0);
        add(LW,  32'h10, 0,            0, 32'h11223344, 1'b0);
        add(SW,  32'h20, 32'hCAFEBABE, 0, 32'h00000000, 1'b0);
        add(SB,  32'h21, 32'h123456A5, 0, 32'h00000000, 1'b0);
        add(LB,  32'h21, 0,            0, 32'hFFFFFFA5, 1'b0);
        add(LBU, 32'h21, 0,            0, 32'h000000A5, 1'b0);
        add(LW,  32'h20, 0,            0, 32'hCAA5BABE, 1'b0);
        add(LB,  32'h20, 0,            0, 32'hFFFFFFCA, 1'b0);
        add(LBU, 32'h23, 0,            0, 32'h000000BE, 1'b0);
        add(SW,  32'h30, 32'h12345678, 0, 32'h00000000, 1'b0);
        add(SH,  32'h32, 32'hDEAD8001, 0, 32'h00000000, 1'b0);
        add(LH,  32'h32, 0,            0, 32'hFFFF8001, 1'b0);
        add(LHU, 32'h32, 0,            0, 32'h00008001, 1'b0);
        add(LHU, 32'h30, 0,            0, 32'h00001234, 1'b0);
        add(LH,  32'h30, 0,            0, 32'h00001234, 1'b0);
        add(SW,  32'h00, 32'hAAAA0001, 0, 32'h00000000, 1'b0);
        add(SW,  32'h04, 32'h55550002, 0, 32'h00000000, 1'b0);
        add(LW,  32'h00, 0,            0, 32'hAAAA0001, 1'b0);
        add(LW,  32'h04, 0,            0, 32'h55550002, 1'b0);
        add(ADD, 32'hDEADBEEF, 0, 32'h00400004, 32'hDEADBEEF, 1'b0);
        add(JAL, 32'hDEADBEEF, 0, 32'h00400008, 32'h00400008, 1'b0);
        add(SW,  32'h1000, 32'h0BADF00D, 0, 32'h00000000, 1'b0);
        add(LW,  32'h00, 0,            0, 32'h0BADF00D, 1'b0);
        add(LW,  32'h1004, 0,          0, 32'h55550002, 1'b0);
`ifdef DM_MISALIGN_TRAP_EN
        add(SW,  32'h02, 32'hFFFFFFFF, 0, 32'h00000000, 1'b1);
        add(LW,  32'h00, 0,            0, 32'h0BADF00D, 1'b0);
        add(LW,  32'h06, 0,            0, 32'h00000000, 1'b1);
        add(LH,  32'h31, 0,            0, 32'h00000000, 1'b1);
        add(LB,  32'h31, 0,            0, 32'h00000034, 1'b0);
`else
        add(SW,  32'h43, 32'h77665544, 0, 32'h00000000, 1'b0);
        add(LW,  32'h40, 0,            0, 32'h77665544, 1'b0);
        add(LH,  32'h41, 0,            0, 32'h00007766, 1'b0);
        add(LH,  32'h43, 0,            0, 32'h00005544, 1'b0);
        add(LB,  32'h43, 0,            0, 32'h00000044, 1'b0);
`endif

        repeat (2) @(posedge CLK);
        @(negedge CLK);
        check("rst_stall", {31'b0, Stall}, 32'h0);
        check("rst_exc", {31'b0, Exc}, 32'h0);
        check("rst_rdata", Rdata, 32'h5A5A5A5A);
        @(posedge CLK);
        #1;
        RST = 1'b1;

        run_table(0);

        // Abandon a load in WAIT via asynchronous reset.
        Ins = {LW, 26'h0};
        Adr = 32'h10;
        @(posedge CLK);
        #1;
        check("wait_stall", {31'b0, Stall}, 32'h1);
        RST = 1'b0;
        @(negedge CLK);
        check("rstwait_stall", {31'b0, Stall}, 32'h0);
        check("rstwait_exc", {31'b0, Exc}, 32'h0);
        @(posedge CLK);
        #1;
        RST = 1'b1;
        add(ADD, 32'h12345678, 0, 0, 32'h12345678, 1'b0);
        add(LW,  32'h10,       0, 0, 32'h11223344, 1'b0);
        run_table(100);

        checks++;
        if (q_exp.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", q_exp.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
